// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war match controller.
package tug_pkg;

  localparam int SCORE_W = 3;
  localparam int AI_W    = 9;

  typedef enum logic [2:0] {
    IDLE,
    SERVE,
    PLAY,
    ROUND_END,
    MATCH_OVER
  } tug_state_t;

  localparam logic [1:0] WIN_NONE  = 2'b00;
  localparam logic [1:0] WIN_RIGHT = 2'b01;
  localparam logic [1:0] WIN_LEFT  = 2'b10;

  // Bits needed to hold the larger of two cycle counts minus one.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/tug_match_ctrl_if.sv
// Game-side signals of the match controller: win inputs, start, field control and scores.
interface tug_match_ctrl_if;
  import tug_pkg::*;

  logic               start;
  logic               winL;
  logic               winR;
  logic               field_reset;
  logic               play_en;
  logic [SCORE_W-1:0] scoreL;
  logic [SCORE_W-1:0] scoreR;
  logic [1:0]         round_winner;
  logic               match_over;
  logic [AI_W-1:0]    ai_threshold;

  modport master (
    output start, winL, winR,
    input  field_reset, play_en, scoreL, scoreR, round_winner, match_over, ai_threshold
  );

  modport slave (
    input  start, winL, winR,
    output field_reset, play_en, scoreL, scoreR, round_winner, match_over, ai_threshold
  );

endinterface

// File: rtl/tug_round_timer.sv
// Loadable down-counter shared by the serve and round-end phases; stops at zero.
module tug_round_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/tug_match_ctrl.sv
// Round/match sequencer for tug-of-war; optional AI threshold ramp under TUG_AI_RAMP_EN.
//   state      | meaning
//   IDLE       | after reset, field held in reset, waiting for start
//   SERVE      | field held in reset for SERVE_CYCLES
//   PLAY       | buttons live, waiting for a single-side win pulse
//   ROUND_END  | result shown for END_CYCLES, buttons gated
//   MATCH_OVER | a side reached WIN_ROUNDS, everything frozen until start
module tug_match_ctrl
  import tug_pkg::*;
#(
  parameter int unsigned     WIN_ROUNDS     = 7,
  parameter int unsigned     SERVE_CYCLES   = 4,
  parameter int unsigned     END_CYCLES     = 8,
  parameter logic [AI_W-1:0] AI_THRESH_INIT = 9'd256
`ifdef TUG_AI_RAMP_EN
  , parameter logic [AI_W-1:0] AI_STEP      = 9'd32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  tug_match_ctrl_if.slave  bus
);

  localparam int TW = tmr_width(int'(SERVE_CYCLES), int'(END_CYCLES));
  localparam logic [TW-1:0]      SERVE_LOAD = TW'(SERVE_CYCLES - 1);
  localparam logic [TW-1:0]      END_LOAD   = TW'(END_CYCLES - 1);
  localparam logic [SCORE_W-1:0] WIN_MAX    = SCORE_W'(WIN_ROUNDS);

  tug_state_t state, state_nx;

  logic [SCORE_W-1:0] score_l, score_r;
  logic [SCORE_W-1:0] score_l_inc, score_r_inc;
  logic [1:0]         round_winner;

  logic          tmr_load, tmr_en, tmr_zero;
  logic [TW-1:0] tmr_val;
  logic          new_match, enter_serve, inc_r, inc_l;

  assign score_l_inc = score_l + 1'b1;
  assign score_r_inc = score_r + 1'b1;

  tug_round_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    tmr_load    = 1'b0;
    tmr_val     = SERVE_LOAD;
    tmr_en      = (state == SERVE) || (state == ROUND_END);
    new_match   = 1'b0;
    enter_serve = 1'b0;
    inc_r       = 1'b0;
    inc_l       = 1'b0;
    case (state)
      IDLE, MATCH_OVER: begin
        if (bus.start) begin
          state_nx    = SERVE;
          tmr_load    = 1'b1;
          new_match   = 1'b1;
          enter_serve = 1'b1;
        end
      end
      SERVE: begin
        if (tmr_zero) state_nx = PLAY;
      end
      PLAY: begin
        // Simultaneous wins cancel out and the round simply continues.
        if (bus.winR && !bus.winL) begin
          inc_r = 1'b1;
          if (score_r_inc == WIN_MAX) begin
            state_nx = MATCH_OVER;
          end else begin
            state_nx = ROUND_END;
            tmr_load = 1'b1;
            tmr_val  = END_LOAD;
          end
        end else if (bus.winL && !bus.winR) begin
          inc_l = 1'b1;
          if (score_l_inc == WIN_MAX) begin
            state_nx = MATCH_OVER;
          end else begin
            state_nx = ROUND_END;
            tmr_load = 1'b1;
            tmr_val  = END_LOAD;
          end
        end
      end
      ROUND_END: begin
        if (tmr_zero) begin
          state_nx    = SERVE;
          tmr_load    = 1'b1;
          enter_serve = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_l      <= '0;
      score_r      <= '0;
      round_winner <= WIN_NONE;
    end else begin
      if (new_match) begin
        score_l <= '0;
        score_r <= '0;
      end else if (inc_r) begin
        score_r <= score_r_inc;
      end else if (inc_l) begin
        score_l <= score_l_inc;
      end

      if (enter_serve) begin
        round_winner <= WIN_NONE;
      end else if (inc_r) begin
        round_winner <= WIN_RIGHT;
      end else if (inc_l) begin
        round_winner <= WIN_LEFT;
      end
    end
  end

`ifdef TUG_AI_RAMP_EN
  logic [AI_W-1:0] ai_thr;

  // Compare in AI_W+1 bits so a large step cannot overflow the floor test.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ai_thr <= AI_THRESH_INIT;
    end else if (new_match) begin
      ai_thr <= AI_THRESH_INIT;
    end else if (inc_r) begin
      if ({1'b0, ai_thr} >= {AI_STEP, 1'b0}) begin
        ai_thr <= ai_thr - AI_STEP;
      end else begin
        ai_thr <= AI_STEP;
      end
    end
  end

  assign bus.ai_threshold = ai_thr;
`else
  assign bus.ai_threshold = AI_THRESH_INIT;
`endif

  assign bus.field_reset  = (state == IDLE) || (state == SERVE);
  assign bus.play_en      = (state == PLAY);
  assign bus.match_over   = (state == MATCH_OVER);
  assign bus.scoreL       = score_l;
  assign bus.scoreR       = score_r;
  assign bus.round_winner = round_winner;

endmodule

// File: tb/tb_tug_match_ctrl.sv
// Directed self-checking bench for tug_match_ctrl (expects TUG_AI_RAMP_EN or not consistently with the RTL build).
module tb_tug_match_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  tug_match_ctrl_if bus();

  tug_match_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [8:0] ai_tab [0:7];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_play(input int budget);
    int n;
    n = 0;
    while (bus.play_en !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check("wait_play_reached", {31'd0, bus.play_en}, 32'd1);
  endtask

  task automatic win_right();
    bus.winR = 1'b1;
    tick();
    bus.winR = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
`ifdef TUG_AI_RAMP_EN
    ai_tab[0] = 9'd256; ai_tab[1] = 9'd224; ai_tab[2] = 9'd192; ai_tab[3] = 9'd160;
    ai_tab[4] = 9'd128; ai_tab[5] = 9'd96;  ai_tab[6] = 9'd64;  ai_tab[7] = 9'd32;
`else
    for (int i = 0; i < 8; i++) ai_tab[i] = 9'd256;
`endif
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.winL  = 1'b0;
    bus.winR  = 1'b0;
    #2;
    check("rst_field_reset", {31'd0, bus.field_reset}, 32'd1);
    check("rst_play_en", {31'd0, bus.play_en}, 32'd0);
    check("rst_scoreL", {29'd0, bus.scoreL}, 32'd0);
    check("rst_scoreR", {29'd0, bus.scoreR}, 32'd0);
    check("rst_round_winner", {30'd0, bus.round_winner}, 32'd0);
    check("rst_match_over", {31'd0, bus.match_over}, 32'd0);
    check("rst_ai", {23'd0, bus.ai_threshold}, 32'd256);
    #10 rst_n = 1'b1;
    tick();

    // IDLE ignores wins; start begins serve.
    bus.winR = 1'b1;
    tick();
    bus.winR = 1'b0;
    check("idle_win_ignored", {29'd0, bus.scoreR}, 32'd0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("serve_field_reset_%0d", i), {31'd0, bus.field_reset}, 32'd1);
      check($sformatf("serve_play_en_%0d", i), {31'd0, bus.play_en}, 32'd0);
      bus.winL = (i == 1);
      tick();
    end
    bus.winL = 1'b0;
    check("play_en_5th", {31'd0, bus.play_en}, 32'd1);
    check("play_field_reset", {31'd0, bus.field_reset}, 32'd0);
    check("serve_winL_ignored", {29'd0, bus.scoreL}, 32'd0);

    // Simultaneous wins cancel.
    bus.winL = 1'b1;
    bus.winR = 1'b1;
    tick();
    bus.winL = 1'b0;
    bus.winR = 1'b0;
    check("both_play_en", {31'd0, bus.play_en}, 32'd1);
    check("both_scoreL", {29'd0, bus.scoreL}, 32'd0);
    check("both_scoreR", {29'd0, bus.scoreR}, 32'd0);
    check("both_rw", {30'd0, bus.round_winner}, 32'd0);

    // First right win, then hold ROUND_END for 8 cycles with start ignored.
    win_right();
    check("r1_scoreR", {29'd0, bus.scoreR}, 32'd1);
    check("r1_rw", {30'd0, bus.round_winner}, 32'd1);
    check("r1_play_en", {31'd0, bus.play_en}, 32'd0);
    check("r1_ai", {23'd0, bus.ai_threshold}, {23'd0, ai_tab[1]});
    bus.start = 1'b1;
    for (int i = 1; i < 8; i++) begin
      tick();
      check($sformatf("re_field_reset_%0d", i), {31'd0, bus.field_reset}, 32'd0);
      check($sformatf("re_rw_%0d", i), {30'd0, bus.round_winner}, 32'd1);
    end
    bus.start = 1'b0;
    tick();
    check("re_to_serve_field_reset", {31'd0, bus.field_reset}, 32'd1);
    check("re_to_serve_rw", {30'd0, bus.round_winner}, 32'd0);
    check("re_to_serve_scoreR", {29'd0, bus.scoreR}, 32'd1);

    // A left win does not touch the AI threshold.
    wait_play(30);
    bus.winL = 1'b1;
    tick();
    bus.winL = 1'b0;
    check("l1_scoreL", {29'd0, bus.scoreL}, 32'd1);
    check("l1_rw", {30'd0, bus.round_winner}, 32'd2);
    check("l1_scoreR", {29'd0, bus.scoreR}, 32'd1);
    check("l1_ai", {23'd0, bus.ai_threshold}, {23'd0, ai_tab[1]});

    for (int k = 2; k <= 7; k++) begin
      wait_play(30);
      win_right();
      check($sformatf("r%0d_scoreR", k), {29'd0, bus.scoreR}, k);
      check($sformatf("r%0d_ai", k), {23'd0, bus.ai_threshold}, {23'd0, ai_tab[k]});
      check($sformatf("r%0d_rw", k), {30'd0, bus.round_winner}, 32'd1);
      check($sformatf("r%0d_match_over", k), {31'd0, bus.match_over}, (k == 7) ? 32'd1 : 32'd0);
    end

    // Frozen in MATCH_OVER.
    bus.winR = 1'b1;
    tick();
    tick();
    bus.winR = 1'b0;
    bus.winL = 1'b1;
    tick();
    bus.winL = 1'b0;
    check("mo_scoreR", {29'd0, bus.scoreR}, 32'd7);
    check("mo_scoreL", {29'd0, bus.scoreL}, 32'd1);
    check("mo_match_over", {31'd0, bus.match_over}, 32'd1);
    check("mo_play_en", {31'd0, bus.play_en}, 32'd0);
    check("mo_field_reset", {31'd0, bus.field_reset}, 32'd0);
    check("mo_rw", {30'd0, bus.round_winner}, 32'd1);
    check("mo_ai", {23'd0, bus.ai_threshold}, {23'd0, ai_tab[7]});

    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_scoreR", {29'd0, bus.scoreR}, 32'd0);
    check("restart_scoreL", {29'd0, bus.scoreL}, 32'd0);
    check("restart_field_reset", {31'd0, bus.field_reset}, 32'd1);
    check("restart_match_over", {31'd0, bus.match_over}, 32'd0);
    check("restart_rw", {30'd0, bus.round_winner}, 32'd0);
    check("restart_ai", {23'd0, bus.ai_threshold}, 32'd256);

    // Three right wins, then async reset mid-PLAY.
    for (int k = 1; k <= 3; k++) begin
      wait_play(30);
      win_right();
    end
    wait_play(30);
    check("pre_rst_scoreR", {29'd0, bus.scoreR}, 32'd3);
    check("pre_rst_ai", {23'd0, bus.ai_threshold}, {23'd0, ai_tab[3]});
    #2 rst_n = 1'b0;
    #1;
    check("arst_field_reset", {31'd0, bus.field_reset}, 32'd1);
    check("arst_play_en", {31'd0, bus.play_en}, 32'd0);
    check("arst_scoreR", {29'd0, bus.scoreR}, 32'd0);
    check("arst_scoreL", {29'd0, bus.scoreL}, 32'd0);
    check("arst_rw", {30'd0, bus.round_winner}, 32'd0);
    check("arst_ai", {23'd0, bus.ai_threshold}, 32'd256);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_idle", {31'd0, bus.field_reset}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
